// File: rtl/dff_write_arbiter.sv
// Four-way round-robin arbiter guarding a shared W-bit D register.
// A winner is picked in IDLE, its data lands on the GRANT-exit edge, and
// the grant is held in DONE until the winner drops its request.
module dff_write_arbiter #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   Q,
  output logic [W-1:0]   Qbar,
  output logic           busy,
  output logic [1:0]     last_id,
  output logic [7:0]     wr_count
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t       r_state, w_state_nxt;
  logic [1:0]   r_ptr, r_w, w_win;
  logic [N-1:0] r_gnt;
  logic [W-1:0] r_q;
  logic [1:0]   r_last;
  logic [7:0]   r_cnt;
  logic         w_any, w_grant, w_land, w_release;

  // First set request searching upward from ptr, wrapping 3 -> 0
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    for (int i = 0; i < N; i++) begin
      if (!w_any && req[r_ptr + 2'(i)]) begin
        w_any = 1'b1;
        w_win = r_ptr + 2'(i);
      end
    end
  end

  // State register; reset aborts any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_land      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: if (w_any) begin
        w_grant     = 1'b1;
        w_state_nxt = GRANT;
      end
      // Write always completes, even if the winner already let go
      GRANT: begin
        w_land      = 1'b1;
        w_state_nxt = DONE;
      end
      // Only the winner's request matters until IDLE is re-entered
      DONE: if (!req[r_w]) begin
        w_release   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant, pointer, shared register and bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt  <= '0;
      r_ptr  <= 2'd0;
      r_w    <= 2'd0;
      r_q    <= '0;
      r_last <= 2'd0;
      r_cnt  <= 8'd0;
    end else begin
      if (w_grant) begin
        r_gnt <= N'(1) << w_win;
        r_w   <= w_win;
      end
      if (w_land) begin
        r_q    <= wdata[r_w*W +: W];
        r_last <= r_w;
        r_cnt  <= r_cnt + 8'd1;
      end
      if (w_release) begin
        r_gnt <= '0;
        r_ptr <= r_w + 2'd1;
      end
    end
  end

  assign gnt      = r_gnt;
  assign Q        = r_q;
  assign Qbar     = ~r_q;
  assign busy     = (r_state != IDLE);
  assign last_id  = r_last;
  assign wr_count = r_cnt;

endmodule
